// File: rtl/gbdt_tree_walker.sv
// gbdt_tree_walker: node-fetch sequencer for gradient-boosted decision tree
// inference. It walks a forest held in node RAM one tree after another.
// Internal nodes are handed to an external feature comparator. Leaf values are
// passed to the score accumulator with a valid/ready handshake. The walk ends on
// the leaf of the last tree.
module gbdt_tree_walker #(
   parameter int ADDR_W    = 14,
   parameter int REL_W     = 7,
   parameter int CMP_W     = 9,
   parameter int FEAT_W    = 8,
   parameter int LEAF_W    = 16,
   parameter int RD_LAT    = 1,
   parameter int MAX_DEPTH = 64,
   parameter int ROOT_ADDR = 0,
   parameter int TREE_W    = 10,
   localparam int WORD_W   = 1 + 2*REL_W + CMP_W + FEAT_W
) (
   input  logic              gbdt_clk,
   input  logic              gbdt_rst_n,
   input  logic              start,
   input  logic              abort,
   output logic              ram_rd_en,
   output logic [ADDR_W-1:0] ram_addr,
   input  logic [WORD_W-1:0] ram_rdata,
   output logic              cmp_req,
   output logic [FEAT_W-1:0] feature_num,
   output logic [CMP_W-1:0]  cmp_value,
   input  logic              cmp_ack,
   input  logic              cmp_go_right,
   output logic              leaf_valid,
   output logic [LEAF_W-1:0] leaf_val,
   output logic [TREE_W-1:0] leaf_tree,
   input  logic              leaf_ready,
   output logic              busy,
   output logic              done,
   output logic              err_depth
);

   localparam int LAT_W   = $clog2(RD_LAT + 1);
   localparam int DEPTH_W = $clog2(MAX_DEPTH + 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT,
      S_EVAL,
      S_EMIT,
      S_DONE
   } state_t;

   state_t              state;
   logic [ADDR_W-1:0]   cur_addr;
   logic [TREE_W-1:0]   tree_cnt;
   logic [DEPTH_W-1:0]  depth;
   logic [LAT_W-1:0]    lat_cnt;
   // Bit 0 (is_leaf) is consumed at capture time and steers the FSM, so only
   // the payload above it is kept.
   logic [WORD_W-1:1]   node;

   // Node word field views
   logic [REL_W-1:0]    rel_right;
   logic [REL_W-1:0]    rel_left;
   logic [REL_W-1:0]    rel_sel;
   logic [ADDR_W-1:0]   child_addr;
   logic [DEPTH_W-1:0]  depth_inc;
   logic                last_tree;
   logic [ADDR_W-1:0]   next_tree;

   assign rel_right  = node[REL_W:1];
   assign rel_left   = node[2*REL_W:REL_W+1];
   assign rel_sel    = cmp_go_right ? rel_right : rel_left;
   // Child offsets are unsigned and wrap modulo the RAM size
   assign child_addr = cur_addr + {{(ADDR_W-REL_W){1'b0}}, rel_sel};
   assign depth_inc  = depth + DEPTH_W'(1);
   assign last_tree  = node[1];
   assign next_tree  = node[ADDR_W+1:2];

   // The field outputs are gated by the registered strobes, so they read zero
   // whenever their handshake is not active.
   assign ram_addr    = cur_addr;
   assign busy        = (state != S_IDLE);
   assign feature_num = cmp_req    ? node[WORD_W-1 -: FEAT_W]          : '0;
   assign cmp_value   = cmp_req    ? node[2*REL_W+CMP_W:2*REL_W+1]     : '0;
   assign leaf_val    = leaf_valid ? node[WORD_W-1 -: LEAF_W]          : '0;
   assign leaf_tree   = leaf_valid ? tree_cnt                          : '0;

   // Walk sequencer: state, walk context and registered strobes
   always_ff @(posedge gbdt_clk or negedge gbdt_rst_n) begin
      if (!gbdt_rst_n) begin
         state      <= S_IDLE;
         cur_addr   <= ADDR_W'(ROOT_ADDR);
         tree_cnt   <= '0;
         depth      <= '0;
         lat_cnt    <= '0;
         node       <= '0;
         ram_rd_en  <= 1'b0;
         cmp_req    <= 1'b0;
         leaf_valid <= 1'b0;
         done       <= 1'b0;
         err_depth  <= 1'b0;
      end else if (abort) begin
         // Abort wins over everything, including start. The error flag is kept.
         state      <= S_IDLE;
         ram_rd_en  <= 1'b0;
         cmp_req    <= 1'b0;
         leaf_valid <= 1'b0;
         done       <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  err_depth <= 1'b0;
                  tree_cnt  <= '0;
                  depth     <= '0;
                  cur_addr  <= ADDR_W'(ROOT_ADDR);
                  ram_rd_en <= 1'b1;
                  state     <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               ram_rd_en <= 1'b0;
               lat_cnt   <= LAT_W'(1);
               state     <= S_WAIT;
            end
            S_WAIT: begin
               if (lat_cnt == LAT_W'(RD_LAT)) begin
                  node <= ram_rdata[WORD_W-1:1];
                  if (ram_rdata[0]) begin
                     leaf_valid <= 1'b1;
                     state      <= S_EMIT;
                  end else begin
                     cmp_req <= 1'b1;
                     state   <= S_EVAL;
                  end
               end else begin
                  lat_cnt <= lat_cnt + LAT_W'(1);
               end
            end
            S_EVAL: begin
               if (cmp_ack) begin
                  cmp_req  <= 1'b0;
                  depth    <= depth_inc;
                  cur_addr <= child_addr;
                  if (depth_inc == DEPTH_W'(MAX_DEPTH)) begin
                     // The tree is too deep or has a cycle. Give up without done.
                     err_depth <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     ram_rd_en <= 1'b1;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_EMIT: begin
               if (leaf_ready) begin
                  leaf_valid <= 1'b0;
                  if (last_tree) begin
                     done  <= 1'b1;
                     state <= S_DONE;
                  end else begin
                     cur_addr  <= next_tree;
                     tree_cnt  <= tree_cnt + TREE_W'(1);
                     depth     <= '0;
                     ram_rd_en <= 1'b1;
                     state     <= S_ISSUE;
                  end
               end
            end
            S_DONE: begin
               done     <= 1'b0;
               cur_addr <= ADDR_W'(ROOT_ADDR);
               state    <= S_IDLE;
            end
            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_gbdt_tree_walker.sv
// Directed bench for gbdt_tree_walker.
// Instance a: RD_LAT=1, MAX_DEPTH=64. Instance b: RD_LAT=3, MAX_DEPTH=4.
// Each instance has its own node RAM model.
module tb_gbdt_tree_walker;

    localparam int ADDR_W = 14;
    localparam int WORD_W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    logic              a_start, a_abort, a_ack, a_right, a_ready;
    logic              a_rd_en, a_cmp_req, a_lv, a_busy, a_done, a_err;
    logic [ADDR_W-1:0] a_addr;
    logic [WORD_W-1:0] a_rdata;
    logic [7:0]        a_feat;
    logic [8:0]        a_cval;
    logic [15:0]       a_lval;
    logic [9:0]        a_ltree;

    logic              b_start, b_abort, b_ack, b_right, b_ready;
    logic              b_rd_en, b_cmp_req, b_lv, b_busy, b_done, b_err;
    logic [ADDR_W-1:0] b_addr;
    logic [WORD_W-1:0] b_rdata;
    logic [7:0]        b_feat;
    logic [8:0]        b_cval;
    logic [15:0]       b_lval;
    logic [9:0]        b_ltree;

    logic [WORD_W-1:0] mem_a [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] mem_b [0:(1<<ADDR_W)-1];
    logic [WORD_W-1:0] b_p1, b_p2;
    int                a_done_cnt = 0;
    int                b_done_cnt = 0;

    gbdt_tree_walker #(.RD_LAT(1), .MAX_DEPTH(64)) u_a (
        .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(a_start), .abort(a_abort),
        .ram_rd_en(a_rd_en), .ram_addr(a_addr), .ram_rdata(a_rdata),
        .cmp_req(a_cmp_req), .feature_num(a_feat), .cmp_value(a_cval),
        .cmp_ack(a_ack), .cmp_go_right(a_right), .leaf_valid(a_lv),
        .leaf_val(a_lval), .leaf_tree(a_ltree), .leaf_ready(a_ready),
        .busy(a_busy), .done(a_done), .err_depth(a_err)
    );

    gbdt_tree_walker #(.RD_LAT(3), .MAX_DEPTH(4)) u_b (
        .gbdt_clk(clk), .gbdt_rst_n(rst_n), .start(b_start), .abort(b_abort),
        .ram_rd_en(b_rd_en), .ram_addr(b_addr), .ram_rdata(b_rdata),
        .cmp_req(b_cmp_req), .feature_num(b_feat), .cmp_value(b_cval),
        .cmp_ack(b_ack), .cmp_go_right(b_right), .leaf_valid(b_lv),
        .leaf_val(b_lval), .leaf_tree(b_ltree), .leaf_ready(b_ready),
        .busy(b_busy), .done(b_done), .err_depth(b_err)
    );

    // RAM models. Off-strobe cycles load a junk word, so a capture that comes
    // at the wrong time sees bad data.
    always @(posedge clk) begin
        a_rdata <= a_rd_en ? mem_a[a_addr] : 32'hFFFF_FFFF;
        b_p1    <= b_rd_en ? mem_b[b_addr] : 32'hFFFF_FFFF;
        b_p2    <= b_p1;
        b_rdata <= b_p2;
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    function automatic logic [31:0] mk_leaf(input logic last, input logic [13:0] nxt,
                                            input logic [15:0] val);
        return {val, nxt, last, 1'b1};
    endfunction

    function automatic logic [31:0] mk_int(input logic [7:0] f, input logic [8:0] c,
                                           input logic [6:0] rl, input logic [6:0] rr);
        return {f, c, rl, rr, 1'b0};
    endfunction

    task automatic wait_a_lv();
        int n = 0;
        while (a_lv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (a_lv !== 1'b1) begin errors++; $display("FAIL a_leaf_valid_timeout observed %0h expected 1", a_lv); end
    endtask

    task automatic wait_a_req();
        int n = 0;
        while (a_cmp_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (a_cmp_req !== 1'b1) begin errors++; $display("FAIL a_cmp_req_timeout observed %0h expected 1", a_cmp_req); end
    endtask

    task automatic wait_b_lv();
        int n = 0;
        while (b_lv !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (b_lv !== 1'b1) begin errors++; $display("FAIL b_leaf_valid_timeout observed %0h expected 1", b_lv); end
    endtask

    task automatic wait_b_req();
        int n = 0;
        while (b_cmp_req !== 1'b1 && n < 40) begin @(negedge clk); n++; end
        checks++;
        if (b_cmp_req !== 1'b1) begin errors++; $display("FAIL b_cmp_req_timeout observed %0h expected 1", b_cmp_req); end
    endtask

    task automatic run_branch(input logic right, input logic [13:0] exp_addr,
                              input logic [15:0] exp_val);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a_req();
        checks++;
        if (a_feat !== 8'h11) begin errors++; $display("FAIL br_feature observed %0h expected 11", a_feat); end
        checks++;
        if (a_cval !== 9'h0AB) begin errors++; $display("FAIL br_cmp_value observed %0h expected ab", a_cval); end
        a_ack = 1'b1;
        a_right = right;
        @(negedge clk);
        a_ack = 1'b0;
        checks++;
        if (a_rd_en !== 1'b1) begin errors++; $display("FAIL br_rd_en observed %0h expected 1", a_rd_en); end
        checks++;
        if (a_addr !== exp_addr) begin errors++; $display("FAIL br_child_addr observed %0h expected %0h", a_addr, exp_addr); end
        checks++;
        if (a_cmp_req !== 1'b0) begin errors++; $display("FAIL br_cmp_req_drop observed %0h expected 0", a_cmp_req); end
        checks++;
        if (a_feat !== 8'h00) begin errors++; $display("FAIL br_feature_zero observed %0h expected 0", a_feat); end
        wait_a_lv();
        checks++;
        if (a_lval !== exp_val) begin errors++; $display("FAIL br_leaf_val observed %0h expected %0h", a_lval, exp_val); end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL br_done observed %0h expected 1", a_done); end
        @(negedge clk);
    endtask

    initial begin
        int n;
        int dc;
        a_start = 0; a_abort = 0; a_ack = 0; a_right = 0; a_ready = 0;
        b_start = 0; b_abort = 0; b_ack = 0; b_right = 0; b_ready = 0;
        repeat (3) @(negedge clk);

        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL rst_busy observed %0h expected 0", a_busy); end
        checks++;
        if (a_rd_en !== 1'b0) begin errors++; $display("FAIL rst_rd_en observed %0h expected 0", a_rd_en); end
        checks++;
        if (a_addr !== 14'h0) begin errors++; $display("FAIL rst_addr observed %0h expected 0", a_addr); end
        checks++;
        if (a_lv !== 1'b0) begin errors++; $display("FAIL rst_leaf_valid observed %0h expected 0", a_lv); end
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL rst_done observed %0h expected 0", a_done); end
        checks++;
        if (a_err !== 1'b0) begin errors++; $display("FAIL rst_err observed %0h expected 0", a_err); end
        checks++;
        if (b_cmp_req !== 1'b0) begin errors++; $display("FAIL rst_b_cmp_req observed %0h expected 0", b_cmp_req); end
        rst_n = 1'b1;
        @(negedge clk);

        mem_a[0] = mk_leaf(1'b1, 14'h0, 16'h1234);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        checks++;
        if (a_rd_en !== 1'b1) begin errors++; $display("FAIL t1_rd_en observed %0h expected 1", a_rd_en); end
        checks++;
        if (a_addr !== 14'h0) begin errors++; $display("FAIL t1_addr observed %0h expected 0", a_addr); end
        checks++;
        if (a_busy !== 1'b1) begin errors++; $display("FAIL t1_busy observed %0h expected 1", a_busy); end
        @(negedge clk);
        checks++;
        if (a_rd_en !== 1'b0) begin errors++; $display("FAIL t1_rd_en_one_cycle observed %0h expected 0", a_rd_en); end
        checks++;
        if (a_lv !== 1'b0) begin errors++; $display("FAIL t1_no_leaf_yet observed %0h expected 0", a_lv); end
        @(negedge clk);
        checks++;
        if (a_lv !== 1'b1) begin errors++; $display("FAIL t1_leaf_valid observed %0h expected 1", a_lv); end
        checks++;
        if (a_lval !== 16'h1234) begin errors++; $display("FAIL t1_leaf_val observed %0h expected 1234", a_lval); end
        checks++;
        if (a_ltree !== 10'd0) begin errors++; $display("FAIL t1_leaf_tree observed %0h expected 0", a_ltree); end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL t1_done observed %0h expected 1", a_done); end
        checks++;
        if (a_lv !== 1'b0) begin errors++; $display("FAIL t1_leaf_drop observed %0h expected 0", a_lv); end
        @(negedge clk);
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse observed %0h expected 0", a_done); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL t1_idle observed %0h expected 0", a_busy); end

        mem_a[0] = mk_int(8'h11, 9'h0AB, 7'd3, 7'd5);
        mem_a[5] = mk_leaf(1'b1, 14'h0, 16'h0055);
        mem_a[3] = mk_leaf(1'b1, 14'h0, 16'h0033);
        run_branch(1'b1, 14'h0005, 16'h0055);
        run_branch(1'b0, 14'h0003, 16'h0033);

        mem_a[0]      = mk_leaf(1'b0, 14'h0040, 16'h0AAA);
        mem_a[14'h40] = mk_leaf(1'b1, 14'h0, 16'h0BBB);
        dc = a_done_cnt;
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a_lv();
        checks++;
        if (a_ltree !== 10'd0) begin errors++; $display("FAIL t3_tree0 observed %0h expected 0", a_ltree); end
        checks++;
        if (a_lval !== 16'h0AAA) begin errors++; $display("FAIL t3_val0 observed %0h expected aaa", a_lval); end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        checks++;
        if (a_rd_en !== 1'b1) begin errors++; $display("FAIL t3_next_rd_en observed %0h expected 1", a_rd_en); end
        checks++;
        if (a_addr !== 14'h0040) begin errors++; $display("FAIL t3_next_addr observed %0h expected 40", a_addr); end
        checks++;
        if (a_done !== 1'b0) begin errors++; $display("FAIL t3_no_early_done observed %0h expected 0", a_done); end
        wait_a_lv();
        checks++;
        if (a_ltree !== 10'd1) begin errors++; $display("FAIL t3_tree1 observed %0h expected 1", a_ltree); end
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (a_lv !== 1'b1) begin errors++; $display("FAIL t4_hold_valid observed %0h expected 1", a_lv); end
            checks++;
            if (a_lval !== 16'h0BBB) begin errors++; $display("FAIL t4_hold_val observed %0h expected bbb", a_lval); end
            checks++;
            if (a_rd_en !== 1'b0) begin errors++; $display("FAIL t4_no_rd_en observed %0h expected 0", a_rd_en); end
            @(negedge clk);
        end
        a_ready = 1'b1;
        @(negedge clk);
        a_ready = 1'b0;
        checks++;
        if (a_done !== 1'b1) begin errors++; $display("FAIL t3_done observed %0h expected 1", a_done); end
        @(negedge clk);
        checks++;
        if (a_done_cnt - dc !== 1) begin errors++; $display("FAIL t3_single_done observed %0h expected 1", a_done_cnt - dc); end

        mem_a[0] = mk_int(8'h11, 9'h0AB, 7'd1, 7'd1);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        wait_a_req();
        a_abort = 1'b1;
        @(negedge clk);
        a_abort = 1'b0;
        checks++;
        if (a_cmp_req !== 1'b0) begin errors++; $display("FAIL ab_cmp_req observed %0h expected 0", a_cmp_req); end
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL ab_busy observed %0h expected 0", a_busy); end
        checks++;
        if (a_feat !== 8'h00) begin errors++; $display("FAIL ab_feature observed %0h expected 0", a_feat); end
        a_start = 1'b1;
        a_abort = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        a_abort = 1'b0;
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL ab_prio_busy observed %0h expected 0", a_busy); end
        checks++;
        if (a_rd_en !== 1'b0) begin errors++; $display("FAIL ab_prio_rd_en observed %0h expected 0", a_rd_en); end

        mem_b[0]        = mk_leaf(1'b0, 14'h3FFE, 16'h0001);
        mem_b[14'h3FFE] = mk_int(8'h22, 9'h1FF, 7'd5, 7'd5);
        mem_b[3]        = mk_leaf(1'b1, 14'h0, 16'h0777);
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        wait_b_lv();
        checks++;
        if (b_lval !== 16'h0001) begin errors++; $display("FAIL w_val0 observed %0h expected 1", b_lval); end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        checks++;
        if (b_rd_en !== 1'b1) begin errors++; $display("FAIL w_rd_en observed %0h expected 1", b_rd_en); end
        checks++;
        if (b_addr !== 14'h3FFE) begin errors++; $display("FAIL w_addr observed %0h expected 3ffe", b_addr); end
        n = 0;
        do begin @(negedge clk); n++; end while (b_cmp_req !== 1'b1 && n < 20);
        checks++;
        if (n !== 4) begin errors++; $display("FAIL w_latency observed %0h expected 4", n); end
        checks++;
        if (b_feat !== 8'h22) begin errors++; $display("FAIL w_feature observed %0h expected 22", b_feat); end
        checks++;
        if (b_cval !== 9'h1FF) begin errors++; $display("FAIL w_cmp_value observed %0h expected 1ff", b_cval); end
        b_ack = 1'b1;
        b_right = 1'b1;
        @(negedge clk);
        b_ack = 1'b0;
        checks++;
        if (b_rd_en !== 1'b1) begin errors++; $display("FAIL w_wrap_rd_en observed %0h expected 1", b_rd_en); end
        checks++;
        if (b_addr !== 14'h0003) begin errors++; $display("FAIL w_wrap_addr observed %0h expected 3", b_addr); end
        wait_b_lv();
        checks++;
        if (b_lval !== 16'h0777) begin errors++; $display("FAIL w_val1 observed %0h expected 777", b_lval); end
        checks++;
        if (b_ltree !== 10'd1) begin errors++; $display("FAIL w_tree1 observed %0h expected 1", b_ltree); end
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
        checks++;
        if (b_done !== 1'b1) begin errors++; $display("FAIL w_done observed %0h expected 1", b_done); end
        @(negedge clk);

        mem_b[0] = mk_int(8'h01, 9'h002, 7'd0, 7'd0);
        dc = b_done_cnt;
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            wait_b_req();
            b_ack = 1'b1;
            @(negedge clk);
            b_ack = 1'b0;
            if (i < 4) begin
                checks++;
                if (b_rd_en !== 1'b1) begin errors++; $display("FAIL d_reissue observed %0h expected 1", b_rd_en); end
                checks++;
                if (b_err !== 1'b0) begin errors++; $display("FAIL d_no_err observed %0h expected 0", b_err); end
            end else begin
                checks++;
                if (b_busy !== 1'b0) begin errors++; $display("FAIL d_idle observed %0h expected 0", b_busy); end
                checks++;
                if (b_err !== 1'b1) begin errors++; $display("FAIL d_err observed %0h expected 1", b_err); end
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (b_err !== 1'b1) begin errors++; $display("FAIL d_err_sticky observed %0h expected 1", b_err); end
        checks++;
        if (b_done_cnt - dc !== 0) begin errors++; $display("FAIL d_no_done observed %0h expected 0", b_done_cnt - dc); end
        b_start = 1'b1;
        @(negedge clk);
        b_start = 1'b0;
        checks++;
        if (b_err !== 1'b0) begin errors++; $display("FAIL d_err_cleared observed %0h expected 0", b_err); end
        wait_b_req();
        b_abort = 1'b1;
        @(negedge clk);
        b_abort = 1'b0;
        checks++;
        if (b_cmp_req !== 1'b0) begin errors++; $display("FAIL d_abort_cmp_req observed %0h expected 0", b_cmp_req); end
        checks++;
        if (b_busy !== 1'b0) begin errors++; $display("FAIL d_abort_busy observed %0h expected 0", b_busy); end
        checks++;
        if (b_done_cnt - dc !== 0) begin errors++; $display("FAIL d_abort_no_done observed %0h expected 0", b_done_cnt - dc); end

        mem_a[0] = mk_leaf(1'b1, 14'h0, 16'h4321);
        a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL ar_busy observed %0h expected 0", a_busy); end
        checks++;
        if (a_lv !== 1'b0) begin errors++; $display("FAIL ar_leaf_valid observed %0h expected 0", a_lv); end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (a_busy !== 1'b0) begin errors++; $display("FAIL ar_stays_idle observed %0h expected 0", a_busy); end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout observed running expected finished");
        $fatal(1, "timeout");
    end

endmodule
